// File: rtl/sha3_pkg.sv
// Shared SHA3/Keccak constants, types and lane-addressing helper.
package sha3_pkg;

  localparam int unsigned STATE_W         = 1600;
  localparam int unsigned LANE_W          = 64;
  localparam int unsigned NUM_LANES       = 25;
  localparam int unsigned RATE_W_SHA3_256 = 1088;
  localparam int unsigned CAP_W_SHA3_256  = 512;

  typedef logic [STATE_W-1:0]         state_t;
  typedef logic [RATE_W_SHA3_256-1:0] block_t;

  // Bit offset of lane (x,y) inside the flat state vector.
  function automatic int unsigned lane_off(input int unsigned x, input int unsigned y);
    return LANE_W * (x + 5 * y);
  endfunction

endpackage

// File: rtl/sha3_xor_state.sv
// Absorb-phase XOR stage: XORs a rate-sized message block into the sponge
// state and registers the result for the Keccak round core.
module sha3_xor_state #(
  parameter int unsigned STATE_W = 1600,
  parameter int unsigned RATE_W  = 1088
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [RATE_W-1:0]  data_in,
  input  logic [STATE_W-1:0] state,
  input  logic               is_xor,
  output logic [STATE_W-1:0] data_out_r
);
  import sha3_pkg::*;

  localparam int unsigned NumLanes  = STATE_W / LANE_W;
  localparam int unsigned RateLanes = RATE_W / LANE_W;

  if (RATE_W == 0 || RATE_W > STATE_W || (RATE_W % LANE_W) != 0 ||
      (STATE_W % LANE_W) != 0) begin : g_bad_params
    $error("sha3_xor_state: illegal STATE_W/RATE_W combination");
  end

  logic [STATE_W-1:0] data_out_d;
  logic [STATE_W-1:0] data_out_q;

  // Per-lane next state: rate lanes absorb data_in when is_xor, capacity lanes pass through.
  for (genvar i = 0; i < NumLanes; i++) begin : g_lane
    localparam int unsigned Off = lane_off(i % 5, i / 5);
    if (i < RateLanes) begin : g_rate
      assign data_out_d[Off +: LANE_W] = is_xor ? (state[Off +: LANE_W] ^ data_in[Off +: LANE_W])
                                                : state[Off +: LANE_W];
    end else begin : g_cap
      assign data_out_d[Off +: LANE_W] = state[Off +: LANE_W];
    end
  end

  // Output register: updates every cycle, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q <= '0;
    end else begin
      data_out_q <= data_out_d;
    end
  end

  assign data_out_r = data_out_q;

endmodule

// File: tb/tb_sha3_xor_state.sv
// Self-checking bench for sha3_xor_state using an expected-value queue.
module tb_sha3_xor_state;

  localparam int unsigned SW = 1600;
  localparam int unsigned RW = 1088;

  logic          clk;
  logic          rst_n;
  logic [RW-1:0] data_in;
  logic [SW-1:0] state;
  logic          is_xor;
  logic [SW-1:0] data_out_r;

  logic [SW-1:0] exp_q[$];
  int            checks;
  int            errors;

  sha3_xor_state #(
    .STATE_W(SW),
    .RATE_W (RW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .state     (state),
    .is_xor    (is_xor),
    .data_out_r(data_out_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: XOR into the low RW bits only, capacity copied.
  function automatic logic [SW-1:0] model(input logic [SW-1:0] s, input logic [RW-1:0] d,
                                          input logic x);
    logic [SW-1:0] r;
    r = s;
    if (x) r[RW-1:0] = s[RW-1:0] ^ d;
    return r;
  endfunction

  function automatic int ndiff(input logic [SW-1:0] a, input logic [SW-1:0] b);
    int n;
    n = 0;
    for (int i = 0; i < SW; i++) if (a[i] !== b[i]) n++;
    return n;
  endfunction

  function automatic int first_diff(input logic [SW-1:0] a, input logic [SW-1:0] b);
    for (int i = 0; i < SW; i++) if (a[i] !== b[i]) return i;
    return -1;
  endfunction

  function automatic logic [SW-1:0] rand_state();
    logic [SW-1:0] r;
    for (int i = 0; i < SW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Apply inputs on the falling edge and queue the value expected after the next rise.
  task automatic drive(input logic [SW-1:0] s, input logic [RW-1:0] d, input logic x);
    @(negedge clk);
    state   = s;
    data_in = d;
    is_xor  = x;
    exp_q.push_back(model(s, d, x));
  endtask

  task automatic test_reset();
    logic [SW-1:0] zero;
    zero    = '0;
    rst_n   = 1'b0;
    state   = rand_state();
    data_in = rand_state();
    is_xor  = 1'b1;
    #1;
    checks++;
    if (data_out_r !== zero) begin
      errors++;
      $display("FAIL reset_async: %0d bits set, first at %0d, required all zero",
               ndiff(data_out_r, zero), first_diff(data_out_r, zero));
    end
    @(posedge clk);
    #1;
    checks++;
    if (data_out_r !== zero) begin
      errors++;
      $display("FAIL reset_hold: %0d bits set, first at %0d, required all zero",
               ndiff(data_out_r, zero), first_diff(data_out_r, zero));
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_all_ones();
    logic [SW-1:0] exp;
    logic [RW-1:0] ones_r;
    logic [SW-RW-1:0] zero_c;
    ones_r = '1;
    zero_c = '0;
    drive('0, '1, 1'b1);
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    checks++;
    if (data_out_r !== exp) begin
      errors++;
      $display("FAIL all_ones: actual differs from required in %0d bits, first at %0d",
               ndiff(data_out_r, exp), first_diff(data_out_r, exp));
    end
    checks++;
    if (data_out_r[RW-1:0] !== ones_r) begin
      errors++;
      $display("FAIL all_ones_rate: actual low lane %h required %h", data_out_r[63:0], ones_r[63:0]);
    end
    checks++;
    if (data_out_r[SW-1:RW] !== zero_c) begin
      errors++;
      $display("FAIL all_ones_cap: actual cap lane %h required 0", data_out_r[SW-1 -: 64]);
    end
  endtask

  task automatic test_self_cancel();
    logic [SW-1:0] exp;
    logic [RW-1:0] zero_r;
    logic [SW-RW-1:0] ones_c;
    zero_r = '0;
    ones_c = '1;
    drive('1, '1, 1'b1);
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    checks++;
    if (data_out_r !== exp) begin
      errors++;
      $display("FAIL self_cancel: actual differs from required in %0d bits, first at %0d",
               ndiff(data_out_r, exp), first_diff(data_out_r, exp));
    end
    checks++;
    if (data_out_r[RW-1:0] !== zero_r) begin
      errors++;
      $display("FAIL self_cancel_rate: actual low lane %h required 0", data_out_r[63:0]);
    end
    checks++;
    if (data_out_r[SW-1:RW] !== ones_c) begin
      errors++;
      $display("FAIL self_cancel_cap: actual cap lane %h required all ones",
               data_out_r[SW-1 -: 64]);
    end
  endtask

  task automatic test_pass_through();
    logic [SW-1:0] pat;
    logic [SW-1:0] exp;
    pat = {25{64'hA5A5_5A5A_0123_4567}};
    drive(pat, '1, 1'b0);
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    checks++;
    if (data_out_r !== pat || data_out_r !== exp) begin
      errors++;
      $display("FAIL pass_through: actual differs from required in %0d bits, first at %0d",
               ndiff(data_out_r, pat), first_diff(data_out_r, pat));
    end
  endtask

  task automatic test_lane_walk();
    int unsigned ks[4];
    logic [RW-1:0] d;
    logic [SW-1:0] exp;
    ks = '{0, 63, 64, 1087};
    for (int j = 0; j < 4; j++) begin
      d = '0;
      d[ks[j]] = 1'b1;
      drive('0, d, 1'b1);
      @(posedge clk);
      #1;
      exp = exp_q.pop_front();
      checks++;
      if (data_out_r !== exp || ndiff(data_out_r, '0) != 1 || data_out_r[ks[j]] !== 1'b1) begin
        errors++;
        $display("FAIL lane_walk k=%0d: actual has %0d bits set, first at %0d, required only bit %0d",
                 ks[j], ndiff(data_out_r, '0), first_diff(data_out_r, '0), ks[j]);
      end
      checks++;
      if (data_out_r[RW] !== 1'b0) begin
        errors++;
        $display("FAIL lane_walk_bit1088 k=%0d: actual %b required 0", ks[j], data_out_r[RW]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [SW-1:0] exp;
    logic [SW-1:0] zero;
    logic [SW-1:0] s;
    logic [SW-1:0] d;
    zero = '0;
    for (int i = 0; i < 8; i++) begin
      d = rand_state();
      drive(rand_state(), d[RW-1:0], i[0]);
      if (i == 4) begin
        // Assert reset between edges; the queued result must be discarded.
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        checks++;
        if (data_out_r !== zero) begin
          errors++;
          $display("FAIL midreset_async: %0d bits set, first at %0d, required all zero",
                   ndiff(data_out_r, zero), first_diff(data_out_r, zero));
        end
        @(posedge clk);
        #1;
        checks++;
        if (data_out_r !== zero) begin
          errors++;
          $display("FAIL midreset_hold: %0d bits set, first at %0d, required all zero",
                   ndiff(data_out_r, zero), first_diff(data_out_r, zero));
        end
        @(negedge clk);
        rst_n   = 1'b1;
        s       = rand_state();
        d       = rand_state();
        state   = s;
        data_in = d[RW-1:0];
        is_xor  = 1'b1;
        exp_q.push_back(model(s, d[RW-1:0], 1'b1));
      end
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b2b_queue_empty i=%0d: actual 0 entries required 1", i);
      end else begin
        exp = exp_q.pop_front();
        checks++;
        if (data_out_r !== exp) begin
          errors++;
          $display("FAIL b2b i=%0d: actual differs from required in %0d bits, first at %0d",
                   i, ndiff(data_out_r, exp), first_diff(data_out_r, exp));
        end
      end
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    state   = '0;
    data_in = '0;
    is_xor  = 1'b0;
    test_reset();
    test_all_ones();
    test_self_cancel();
    test_pass_through();
    test_lane_walk();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
